// File: rtl/thread_pc_file_pkg.sv
// Shared types and constants for the per-thread PC / run-state store.
package thread_pc_file_pkg;

  localparam int unsigned THREAD_POOL_SIZE = 4;
  localparam int unsigned TID_W            = 2;
  localparam int unsigned XLEN             = 32;
  localparam int unsigned PC_INCR          = 4;

  typedef logic [TID_W-1:0] tid_t;
  typedef logic [XLEN-1:0]  pc_t;

  typedef enum logic {
    INACTIVE = 1'b0,
    ACTIVE   = 1'b1
  } run_state_t;

endpackage

// File: rtl/thread_pc_file_slot.sv
// One thread context: PC register, run flag and the start/halt/redirect/fetch priority mux.
module thread_ctx_slot #(
  parameter int unsigned     XLEN       = thread_pc_file_pkg::XLEN,
  parameter logic [XLEN-1:0] RST_PC     = '0,
  parameter bit              RST_ACTIVE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_hit,
  input  logic [XLEN-1:0] start_pc,
  input  logic            halt_hit,
  input  logic            redirect_hit,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            fetch_hit,
  output logic [XLEN-1:0] pc,
  output logic            active
);
  import thread_pc_file_pkg::*;

  run_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RST_PC;
      state_q <= RST_ACTIVE ? ACTIVE : INACTIVE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (start_hit) begin
      pc_d    = {start_pc[XLEN-1:2], 2'b00};
      state_d = ACTIVE;
    end else if (halt_hit) begin
      state_d = INACTIVE;
    end else if (redirect_hit && state_q == ACTIVE) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (fetch_hit && state_q == ACTIVE) begin
      pc_d = pc_q + XLEN'(PC_INCR);
    end
  end

  assign pc     = pc_q;
  assign active = (state_q == ACTIVE);

endmodule

// File: rtl/thread_pc_file.sv
// Per-thread PC and run-state store; zero-latency read for fetch, tagged
// start/halt/redirect writes from later pipeline stages.
module thread_pc_file #(
  parameter int unsigned     THREAD_POOL_SIZE = thread_pc_file_pkg::THREAD_POOL_SIZE,
  parameter int unsigned     TID_W            = thread_pc_file_pkg::TID_W,
  parameter int unsigned     XLEN             = thread_pc_file_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC         = 32'h0000_0000,
  parameter logic [XLEN-1:0] THREAD_PC_OFFSET = 32'h0000_1000,
  parameter logic [THREAD_POOL_SIZE-1:0] ACTIVE_AT_RESET = 4'b0001
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TID_W-1:0]            fetch_tid_i,
  input  logic                        fetch_valid_i,
  output logic [XLEN-1:0]             pc_o,
  output logic                        pc_valid_o,
  input  logic                        redirect_valid_i,
  input  logic [TID_W-1:0]            redirect_tid_i,
  input  logic [XLEN-1:0]             redirect_pc_i,
  input  logic                        halt_valid_i,
  input  logic [TID_W-1:0]            halt_tid_i,
  input  logic                        start_valid_i,
  input  logic [TID_W-1:0]            start_tid_i,
  input  logic [XLEN-1:0]             start_pc_i,
  output logic [THREAD_POOL_SIZE-1:0] active_mask_o
);

  logic [XLEN-1:0]             slot_pc [THREAD_POOL_SIZE];
  logic [THREAD_POOL_SIZE-1:0] slot_active;

  // TIDs beyond the pool match no slot, so out-of-range requests drop out naturally.
  for (genvar t = 0; t < THREAD_POOL_SIZE; t++) begin : g_slot
    localparam logic [XLEN-1:0] SLOT_RST_PC = RESET_PC + THREAD_PC_OFFSET * XLEN'(t);

    thread_ctx_slot #(
      .XLEN       (XLEN),
      .RST_PC     (SLOT_RST_PC),
      .RST_ACTIVE (ACTIVE_AT_RESET[t])
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .start_hit    (start_valid_i    && start_tid_i    == TID_W'(t)),
      .start_pc     (start_pc_i),
      .halt_hit     (halt_valid_i     && halt_tid_i     == TID_W'(t)),
      .redirect_hit (redirect_valid_i && redirect_tid_i == TID_W'(t)),
      .redirect_pc  (redirect_pc_i),
      .fetch_hit    (fetch_valid_i    && fetch_tid_i    == TID_W'(t)),
      .pc           (slot_pc[t]),
      .active       (slot_active[t])
    );
  end

  always_comb begin
    pc_o       = '0;
    pc_valid_o = 1'b0;
    for (int unsigned i = 0; i < THREAD_POOL_SIZE; i++) begin
      if (fetch_tid_i == TID_W'(i)) begin
        pc_o       = slot_pc[i];
        pc_valid_o = slot_active[i];
      end
    end
  end

  assign active_mask_o = slot_active;

endmodule

// File: tb/tb_thread_pc_file.sv
// Randomised and directed checks of thread_pc_file against an array-based reference model.
module tb_thread_pc_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fetch_tid_i;
  logic        fetch_valid_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        redirect_valid_i;
  logic [1:0]  redirect_tid_i;
  logic [31:0] redirect_pc_i;
  logic        halt_valid_i;
  logic [1:0]  halt_tid_i;
  logic        start_valid_i;
  logic [1:0]  start_tid_i;
  logic [31:0] start_pc_i;
  logic [3:0]  active_mask_o;

  thread_pc_file dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_tid_i      (fetch_tid_i),
    .fetch_valid_i    (fetch_valid_i),
    .pc_o             (pc_o),
    .pc_valid_o       (pc_valid_o),
    .redirect_valid_i (redirect_valid_i),
    .redirect_tid_i   (redirect_tid_i),
    .redirect_pc_i    (redirect_pc_i),
    .halt_valid_i     (halt_valid_i),
    .halt_tid_i       (halt_tid_i),
    .start_valid_i    (start_valid_i),
    .start_tid_i      (start_tid_i),
    .start_pc_i       (start_pc_i),
    .active_mask_o    (active_mask_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] pc_m [4];
  logic [3:0]  act_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int t = 0; t < 4; t++) pc_m[t] = 32'(t) * 32'h1000;
    act_m = 4'b0001;
  endtask

  // One clock of stimulus: drive, check combinational read against model, clock, update model.
  task automatic drive_cycle(input logic [1:0] ftid, input logic fv,
                             input logic rv, input logic [1:0] rtid, input logic [31:0] rpc,
                             input logic hv, input logic [1:0] htid,
                             input logic sv, input logic [1:0] stid, input logic [31:0] spc);
    fetch_tid_i = ftid; fetch_valid_i = fv;
    redirect_valid_i = rv; redirect_tid_i = rtid; redirect_pc_i = rpc;
    halt_valid_i = hv; halt_tid_i = htid;
    start_valid_i = sv; start_tid_i = stid; start_pc_i = spc;
    #3;
    check("pc_o", pc_o, pc_m[ftid]);
    check("pc_valid_o", {31'b0, pc_valid_o}, {31'b0, act_m[ftid]});
    check("active_mask_o", {28'b0, active_mask_o}, {28'b0, act_m});
    @(posedge clk);
    for (int t = 0; t < 4; t++) begin
      if (sv && int'(stid) == t) begin
        pc_m[t] = spc & 32'hFFFF_FFFC;
        act_m[t] = 1'b1;
      end else if (hv && int'(htid) == t) begin
        act_m[t] = 1'b0;
      end else if (rv && int'(rtid) == t && act_m[t]) begin
        pc_m[t] = rpc & 32'hFFFF_FFFC;
      end else if (fv && int'(ftid) == t && act_m[t]) begin
        pc_m[t] = pc_m[t] + 32'd4;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid_i = 1'b0; redirect_valid_i = 1'b0;
    halt_valid_i = 1'b0; start_valid_i = 1'b0;
  endtask

  // Read one thread with constant expectations, no state change.
  task automatic peek(input string tag, input logic [1:0] tid,
                      input logic [31:0] exp_pc, input logic exp_valid);
    idle_inputs();
    fetch_tid_i = tid;
    #1;
    check({tag, "_pc"}, pc_o, exp_pc);
    check({tag, "_valid"}, {31'b0, pc_valid_o}, {31'b0, exp_valid});
  endtask

  initial begin
    rst = 1'b1;
    fetch_tid_i = '0; redirect_tid_i = '0; halt_tid_i = '0; start_tid_i = '0;
    redirect_pc_i = '0; start_pc_i = '0;
    idle_inputs();
    reset_model();
    #2;
    peek("rst_t0", 2'd0, 32'h0000_0000, 1'b1);
    peek("rst_t1", 2'd1, 32'h0000_1000, 1'b0);
    peek("rst_t2", 2'd2, 32'h0000_2000, 1'b0);
    peek("rst_t3", 2'd3, 32'h0000_3000, 1'b0);
    check("rst_mask", {28'b0, active_mask_o}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Sequential fetch on thread 0
    repeat (3) drive_cycle(2'd0, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    peek("seq_t0", 2'd0, 32'h0000_000C, 1'b1);
    peek("seq_t1", 2'd1, 32'h0000_1000, 1'b0);
    peek("seq_t3", 2'd3, 32'h0000_3000, 1'b0);

    // Start with unaligned PC, then redirect beats fetch increment
    drive_cycle(2'd1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b1, 2'd2, 32'h0000_2003);
    check("start_mask", {28'b0, active_mask_o}, 32'h5);
    peek("start_t2", 2'd2, 32'h0000_2000, 1'b1);
    drive_cycle(2'd2, 1'b1, 1'b1, 2'd2, 32'h0000_5000, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    peek("redir_t2", 2'd2, 32'h0000_5000, 1'b1);

    // Start wins over halt; different-thread redirect in the same cycle
    drive_cycle(2'd3, 1'b0, 1'b1, 2'd0, 32'h0000_0040, 1'b1, 2'd1, 1'b1, 2'd1, 32'h0000_0100);
    peek("sh_t1", 2'd1, 32'h0000_0100, 1'b1);
    peek("sh_t0", 2'd0, 32'h0000_0040, 1'b1);

    // Redirect of inactive thread dropped; halted thread does not advance
    drive_cycle(2'd0, 1'b0, 1'b1, 2'd3, 32'h0000_8000, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    peek("drop_t3", 2'd3, 32'h0000_3000, 1'b0);
    drive_cycle(2'd1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0);
    drive_cycle(2'd0, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    peek("halt_t0", 2'd0, 32'h0000_0040, 1'b0);

    // PC wrap
    drive_cycle(2'd1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b1, 2'd0, 32'hFFFF_FFFC);
    drive_cycle(2'd0, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    peek("wrap_t0", 2'd0, 32'h0000_0000, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), $urandom);
    end

    // Asynchronous reset mid-cycle, with requests still asserted
    fetch_tid_i = 2'd2; fetch_valid_i = 1'b1;
    start_valid_i = 1'b1; start_tid_i = 2'd3; start_pc_i = 32'h0000_7777;
    #2;
    rst = 1'b1;
    #1;
    check("arst_mask", {28'b0, active_mask_o}, 32'h1);
    peek("arst_t0", 2'd0, 32'h0000_0000, 1'b1);
    peek("arst_t2", 2'd2, 32'h0000_2000, 1'b0);
    peek("arst_t3", 2'd3, 32'h0000_3000, 1'b0);
    @(posedge clk); #1;
    check("arst_hold_mask", {28'b0, active_mask_o}, 32'h1);
    peek("arst_hold_t1", 2'd1, 32'h0000_1000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/thread_pc_file.md
Name: thread_pc_file

Overview:
Per-thread program-counter and run-state store for the interleaved multithreaded core. It consumes the round-robin fetch thread ID and returns that thread's PC and active flag to the fetch stage in the same cycle. It accepts PC redirects (branch/jump resolution), halt requests and start requests tagged with a thread ID from later pipeline stages. It is the context-holding end of the fetch thread-ID interface.

Parameters:
THREAD_POOL_SIZE, 4, number of hardware thread contexts (1..4)
TID_W, 2, thread ID width
XLEN, 32, PC width
RESET_PC, 32'h0000_0000, reset PC of thread 0
THREAD_PC_OFFSET, 32'h0000_1000, reset PC spacing between threads (thread t resets to RESET_PC + t*THREAD_PC_OFFSET)
ACTIVE_AT_RESET, 4'b0001, per-thread active flag after reset (bit t = thread t)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
fetch_tid_i  in  TID_W  thread selected for fetch this cycle
fetch_valid_i  in  1  fetch stage consumes pc_o this cycle (not stalled)
pc_o  out  XLEN  PC of fetch_tid_i (combinational read of register)
pc_valid_o  out  1  fetch_tid_i is in range and its thread is active
redirect_valid_i  in  1  PC redirect request
redirect_tid_i  in  TID_W  thread to redirect
redirect_pc_i  in  XLEN  redirect target
halt_valid_i  in  1  deactivate a thread
halt_tid_i  in  TID_W  thread to halt
start_valid_i  in  1  activate a thread at a given PC
start_tid_i  in  TID_W  thread to start
start_pc_i  in  XLEN  start PC
active_mask_o  out  THREAD_POOL_SIZE  registered per-thread active flags

Behaviour:
- Reset (async, while rst=1): pc[t] = RESET_PC + t*THREAD_PC_OFFSET, computed mod 2^XLEN; active[t] = ACTIVE_AT_RESET[t]. pc_o and pc_valid_o follow combinationally from reset state and fetch_tid_i; active_mask_o = ACTIVE_AT_RESET[THREAD_POOL_SIZE-1:0].
- Read path is zero-latency: pc_o = pc[fetch_tid_i]; pc_valid_o = (fetch_tid_i < THREAD_POOL_SIZE) && active[fetch_tid_i]. An out-of-range TID gives pc_o = 0 and pc_valid_o = 0.
- All writes take effect at the next rising clk edge and are visible on pc_o in the following cycle.
- Per-thread next-state, evaluated independently for each t. Priority is highest first:
  1. start_valid_i && start_tid_i==t: pc[t] = {start_pc_i[XLEN-1:2],2'b00}; active[t] = 1.
  2. halt_valid_i && halt_tid_i==t: active[t] = 0; pc[t] unchanged.
  3. redirect_valid_i && redirect_tid_i==t && active[t]: pc[t] = {redirect_pc_i[XLEN-1:2],2'b00}.
  4. fetch_valid_i && fetch_tid_i==t && active[t]: pc[t] = pc[t] + 4, wrapping mod 2^XLEN.
  5. Otherwise hold.
- A redirect to an inactive thread is dropped. A fetch of an inactive thread does not advance its PC.
- Requests naming different threads in the same cycle all take effect.
- Requests with TID >= THREAD_POOL_SIZE are ignored.
- Redirect wins over the fetch increment for the same thread. The redirected PC is not incremented in that cycle.
- Starting an already-active thread reloads its PC. Halting an inactive thread has no effect.
- Reset asserted mid-operation discards all pending requests and restores reset state immediately.
- No internal FSM beyond the per-thread two-state run flag (INACTIVE <-> ACTIVE): start moves to ACTIVE, halt moves to INACTIVE, start wins over halt.

Decomposition:
- Shared package: TID_W, THREAD_POOL_SIZE, XLEN, tid_t typedef, pc_t typedef, PC_INCR = 4.
- Natural sub-module: thread_ctx_slot (one per thread, generate loop). It holds pc/active and the priority mux, and takes decoded per-thread hit strobes.
- The top level holds TID decode, range checks and the read mux.

Test Plan:
- Reset with defaults, fetch_tid cycling 0,1,2,3 -> pc_o = 0x0, 0x1000, 0x2000, 0x3000; pc_valid_o = 1,0,0,0; active_mask_o = 4'b0001.
- Thread 0 active, fetch_valid=1 with tid 0 on 3 consecutive cycles -> pc_o reads 0x0, 0x4, 0x8 and pc[0] = 0xC afterwards. Threads 1-3 are unchanged.
- start tid 2 @ 0x2003 -> next cycle active_mask_o = 4'b0101 and pc[2] = 0x2000. Then redirect tid 2 to 0x5000 together with fetch tid 2 in the same cycle -> pc[2] = 0x5000, not 0x5004.
- Same cycle: start tid 1 @ 0x100, halt tid 1, redirect tid 0 to 0x40 -> thread 1 active with pc 0x100, and pc[0] = 0x40.
- Redirect tid 3 while thread 3 is inactive -> pc[3] stays 0x3000. Then halt tid 0 -> fetch tid 0 gives pc_valid_o = 0 and its PC does not advance.
- PC wrap: start tid 0 @ 0xFFFF_FFFC, fetch once -> pc[0] = 0x0. Then assert rst mid-sequence asynchronously -> all PCs and the mask return to reset values before the next clk edge.
